// File: rtl/ysyx_23060025_pc_gen_pkg.sv
// Shared definitions for the next-PC generator.
// Holds the fetch sequencer state encoding, the default reset PC,
// the conventional redirect source indices and an index-width helper.
package ysyx_23060025_pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } pcgen_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

    // Redirect source indices; a lower index wins arbitration.
    localparam int REDIR_BRANCH = 0;
    localparam int REDIR_JMP    = 1;
    localparam int REDIR_CSR    = 2;

    // Width of an index able to name n sources (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_23060025_redir_arb.sv
// Fixed-priority redirect selector.
// Given a valid vector and the matching packed targets, reports whether any
// entry is valid and returns the lowest valid index with its target.
// Entry k occupies target_i[k*ADDR_LEN +: ADDR_LEN].
module ysyx_23060025_redir_arb
    import ysyx_23060025_pc_gen_pkg::*;
#(
    parameter int NUM      = 3,
    parameter int ADDR_LEN = 32
) (
    input  logic [NUM-1:0]            valid_i,
    input  logic [NUM*ADDR_LEN-1:0]   target_i,
    output logic                      any_o,
    output logic [idx_width(NUM)-1:0] idx_o,
    output logic [ADDR_LEN-1:0]       target_o
);

    localparam int IDX_W = idx_width(NUM);

    // Scan from the highest index down so the lowest valid index is the last write.
    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        target_o = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (valid_i[k]) begin
                any_o    = 1'b1;
                idx_o    = IDX_W'(k);
                target_o = target_i[k*ADDR_LEN +: ADDR_LEN];
            end
        end
    end

endmodule

// File: rtl/ysyx_23060025_pc_gen.sv
// Next-PC generator and fetch-request sequencer.
// Holds the fetch PC, issues one valid/ready request per instruction and
// advances only when the current instruction reports done. Redirects from
// several prioritised sources are merged into a single pending slot until
// the advance consumes them.
// Optional build macro YSYX_23060025_PCGEN_MISALIGN_CHECK_EN: redirect
// targets with nonzero low bits are aligned down to 4 bytes and flagged
// on misalign_o; without it targets are used verbatim and misalign_o is 0.
module ysyx_23060025_pc_gen
    import ysyx_23060025_pc_gen_pkg::*;
#(
    parameter int                  ADDR_LEN     = 32,
    parameter int                  NUM_REDIR    = 3,
    parameter logic [ADDR_LEN-1:0] PC_RESET_VAL = ADDR_LEN'(PC_RESET_DEFAULT),
    parameter int                  STEP         = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REDIR-1:0]          redir_valid_i,
    input  logic [NUM_REDIR*ADDR_LEN-1:0] redir_target_i,
    input  logic                          done_i,
    input  logic                          fetch_ready_i,
    output logic                          fetch_valid_o,
    output logic [ADDR_LEN-1:0]           fetch_pc_o,
    output logic [ADDR_LEN-1:0]           pc_next_o,
    output logic                          redirect_o,
    output logic                          misalign_o
);

    localparam int IDX_W = idx_width(NUM_REDIR);

    pcgen_state_e          state_q;
    pcgen_state_e          state_d;
    logic [ADDR_LEN-1:0]   fetch_pc_q;
    logic                  pend_valid_q;
    logic [IDX_W-1:0]      pend_idx_q;
    logic [ADDR_LEN-1:0]   pend_target_q;
    logic                  redirect_q;

    logic                  live_any;
    logic [IDX_W-1:0]      live_idx;
    logic [ADDR_LEN-1:0]   live_target;
    logic                  live_wins;

    logic                  merge_any;
    logic [0:0]            merge_sel;
    logic [ADDR_LEN-1:0]   merge_target;
    logic [IDX_W-1:0]      merge_idx;

    logic                  advance;
    logic                  latch_en;
    logic                  use_redir;
    logic [ADDR_LEN-1:0]   redir_target;
    logic [ADDR_LEN-1:0]   seq_pc;
    logic [ADDR_LEN-1:0]   pc_next;

    // Lowest-index live redirect request this cycle.
    ysyx_23060025_redir_arb #(
        .NUM      (NUM_REDIR),
        .ADDR_LEN (ADDR_LEN)
    ) u_live_arb (
        .valid_i  (redir_valid_i),
        .target_i (redir_target_i),
        .any_o    (live_any),
        .idx_o    (live_idx),
        .target_o (live_target)
    );

    // The live request beats the pending one on equal or higher priority.
    assign live_wins = live_any && (!pend_valid_q || (live_idx <= pend_idx_q));

    // Merge between the winning live request (slot 0) and the pending one (slot 1).
    ysyx_23060025_redir_arb #(
        .NUM      (2),
        .ADDR_LEN (ADDR_LEN)
    ) u_merge_arb (
        .valid_i  ({pend_valid_q, live_wins}),
        .target_i ({pend_target_q, live_target}),
        .any_o    (merge_any),
        .idx_o    (merge_sel),
        .target_o (merge_target)
    );

    assign merge_idx = merge_sel[0] ? pend_idx_q : live_idx;

    assign advance  = (state_q == WAIT) && done_i;
    assign latch_en = (state_q != BOOT) && live_any && !advance;
    assign seq_pc   = fetch_pc_q + ADDR_LEN'(STEP);

    // Pick the redirect target that an advance would use this cycle.
    always_comb begin
        use_redir    = pend_valid_q;
        redir_target = pend_target_q;
        if (done_i && live_wins) begin
            use_redir    = 1'b1;
            redir_target = live_target;
        end
    end

`ifdef YSYX_23060025_PCGEN_MISALIGN_CHECK_EN
    logic misalign_q;
    logic target_misaligned;

    assign target_misaligned = |redir_target[1:0];

    // Next PC: redirect target aligned down to a word, else sequential.
    always_comb begin
        pc_next = seq_pc;
        if (use_redir) begin
            pc_next = {redir_target[ADDR_LEN-1:2], 2'b00};
        end
    end

    // Flag an advance that had to align its redirect target.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= advance && use_redir && target_misaligned;
        end
    end

    assign misalign_o = misalign_q;
`else
    // Next PC: redirect target verbatim, else sequential.
    always_comb begin
        pc_next = seq_pc;
        if (use_redir) begin
            pc_next = redir_target;
        end
    end

    assign misalign_o = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer transitions: boot once, request until accepted, wait for done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = REQ;
            REQ:     if (fetch_ready_i) state_d = WAIT;
            WAIT:    if (done_i) state_d = REQ;
            default: state_d = BOOT;
        endcase
    end

    // Fetch PC only moves on an advance, so it is stable across a handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= PC_RESET_VAL;
        end else if (advance) begin
            fetch_pc_q <= pc_next;
        end
    end

    // Pending flag: cleared by an advance, set by any latched redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
        end else if (advance) begin
            pend_valid_q <= 1'b0;
        end else if (latch_en) begin
            pend_valid_q <= merge_any;
        end
    end

    // Pending payload; only meaningful while the pending flag is set.
    always_ff @(posedge clock) begin
        if (latch_en) begin
            pend_idx_q    <= merge_idx;
            pend_target_q <= merge_target;
        end
    end

    // One-cycle pulse after an advance that took a redirect target.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= advance && use_redir;
        end
    end

    assign fetch_valid_o = (state_q == REQ);
    assign fetch_pc_o    = fetch_pc_q;
    assign pc_next_o     = pc_next;
    assign redirect_o    = redirect_q;

endmodule

// File: doc/ysyx_23060025_pc_gen.md
Name: ysyx_23060025_pc_gen

Overview:
- Parametrised next-PC generator and fetch-request sequencer.
- Replaces the single-cycle PC register with N prioritised redirect sources, a pending-redirect latch and a valid/ready fetch handshake to the IFU.
- Sits between EXU/CSR redirect outputs and the IFU.
- Advances the PC only when the current instruction is reported done.

Parameters:
- ADDR_LEN, 32, PC width in bits.
- NUM_REDIR, 3, number of redirect sources; index 0 has highest priority (branch, jump, csr by convention).
- PC_RESET_VAL, 32'h8000_0000, PC after reset.
- STEP, 4, sequential increment in bytes.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- redir_valid_i  in  NUM_REDIR  per-source redirect request, single-cycle pulse.
- redir_target_i  in  NUM_REDIR*ADDR_LEN  packed targets; source k occupies bits [k*ADDR_LEN +: ADDR_LEN].
- done_i  in  1  current instruction complete, permission to advance.
- fetch_ready_i  in  1  IFU accepts the request.
- fetch_valid_o  out  1  fetch request valid.
- fetch_pc_o  out  ADDR_LEN  PC being fetched.
- pc_next_o  out  ADDR_LEN  combinational next PC (for difftest).
- redirect_o  out  1  one-cycle pulse: the PC just advanced via a redirect.
- misalign_o  out  1  misalign pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync deassert handled upstream): fetch_pc_o=PC_RESET_VAL, state=BOOT, fetch_valid_o=0, redirect_o=0, misalign_o=0, pending cleared.
- FSM states: BOOT, REQ, WAIT.
  - BOOT -> REQ unconditionally after 1 cycle.
  - REQ: fetch_valid_o=1. fetch_pc_o must stay stable until fetch_ready_i; REQ -> WAIT on fetch_valid_o & fetch_ready_i.
  - WAIT: fetch_valid_o=0. On done_i, PC <= pc_next_o and state -> REQ.
  - Fetch latency: the first request after done_i appears on the next cycle.
- Redirect selection: among the live redir_valid_i bits, the lowest index wins (sel_live).
- Pending latch (pend_valid, pend_idx, pend_target):
  - Written in any state except BOOT when any redir_valid_i is set.
  - Replaced only if sel_live index <= pend_idx, or pend_valid=0.
  - Otherwise the new request is dropped.
- pc_next_o:
  - If done_i and a live redirect is present with index <= pend_idx (or no pending): the live target.
  - Else if pend_valid: pend_target.
  - Else: fetch_pc_o+STEP, modulo 2^ADDR_LEN; 32'hFFFF_FFFC wraps to 0.
- Redirects in REQ never alter fetch_pc_o mid-handshake; they are only latched.
- On the done_i advance:
  - Pending is cleared.
  - redirect_o=1 for 1 cycle if a redirect target was used.
  - A live redirect in the same cycle is consumed, not latched.
- done_i outside WAIT: ignored.
- fetch_ready_i outside REQ: ignored.
- Reset mid-handshake: immediate return to the reset values; pending is lost.

Optional Feature:
- Macro: YSYX_23060025_PCGEN_MISALIGN_CHECK_EN.
- Defined: when a selected redirect target has target[1:0]!=0, the PC is loaded with the target with bits [1:0] forced to 0, and misalign_o pulses 1 cycle alongside redirect_o.
- Undefined: targets are used verbatim; misalign_o is constant 0.

Decomposition:
- Shared package/define file: state encodings (BOOT=2'b00, REQ=2'b01, WAIT=2'b10), PC_RESET_VAL default, redirect index names (REDIR_BRANCH=0, REDIR_JMP=1, REDIR_CSR=2).
- One sub-module, ysyx_23060025_redir_arb: parametrised fixed-priority select (valid vector + packed targets -> any, idx, target), used for both the live and merge comparison.

Test Plan:
- Reset and boot: release reset, fetch_ready_i=1 -> fetch_valid_o rises on cycle 2 with fetch_pc_o=32'h8000_0000; done_i -> next request PC 32'h8000_0004, redirect_o=0.
- Handshake stall: hold fetch_ready_i=0 for 5 cycles while pulsing redir_valid_i[1]=1 with target 32'h8000_0100 -> fetch_pc_o stays 32'h8000_0000 throughout; after accept and done_i, PC=32'h8000_0100 and redirect_o pulses.
- Priority merge: in WAIT, pulse src2 with 32'h8000_0200, then src0 with 32'h8000_0300 -> after done_i, PC=32'h8000_0300. Reverse order (src0 then src2) -> PC=32'h8000_0300.
- Same-cycle redirect and done: src1 with target 32'h8000_0040 asserted together with done_i, no pending -> PC=32'h8000_0040 and nothing remains latched; the next done_i gives 32'h8000_0044.
- Wrap: force PC 32'hFFFF_FFFC (via redirect), done_i without redirect -> PC=32'h0000_0000.
- Misalign (macro on): redirect to 32'h8000_0102 -> PC=32'h8000_0100 and misalign_o pulses 1 cycle. Macro off -> PC=32'h8000_0102, misalign_o=0.
